// File: rtl/pe_loop_sequencer.sv
// Per-PE loop controller: walks layer -> k -> c -> a -> w, requests the filter/input
// streams for each k-group, issues one index beat per accepted cycle and hands off to the PPU.
module pe_loop_sequencer #(
  parameter int MAX_LAYERS = 4,
  parameter int K_W        = 6,
  parameter int C_W        = 6,
  parameter int A_W        = 10,
  parameter int W_W        = 10,
  parameter int I          = 4,
  parameter int F          = 4,
  localparam int LW        = $clog2(MAX_LAYERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LW:0]           cfg_num_layers,
  output logic [LW-1:0]         cfg_layer,
  input  logic [K_W-1:0]        cfg_k_count,
  input  logic [C_W-1:0]        cfg_c_count,
  input  logic [W_W-1:0]        cfg_w_count,
  input  logic [A_W-1:0]        cfg_a_count,
  input  logic [(1<<C_W)-1:0]   cfg_sparse_ch,
  input  logic [A_W-1:0]        comp_count,
  output logic                  req_filter_valid,
  output logic                  req_input_valid,
  output logic [K_W-1:0]        req_k,
  input  logic                  filter_done,
  input  logic                  input_done,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [K_W-1:0]        issue_k,
  output logic [C_W-1:0]        issue_c,
  output logic [A_W-1:0]        issue_a,
  output logic [W_W-1:0]        issue_w,
  output logic                  issue_last,
  output logic                  ppu_start,
  input  logic                  ppu_done,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STREAM  = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_SKIP    = 3'd3;
  localparam logic [2:0] S_PPU     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [W_W:0] F_STEP = (W_W+1)'(F);
  localparam logic [A_W:0] I_STEP = (A_W+1)'(I);

  logic [2:0]   r_state;
  logic [LW:0]  r_layer;
  logic [LW:0]  r_num_layers;
  logic [K_W:0] r_k;
  logic [C_W:0] r_c;
  logic [A_W:0] r_a;
  logic [A_W:0] r_a_lim;
  logic [W_W:0] r_w;
  logic         r_filter_flag;
  logic         r_input_flag;
  logic         r_ch_first;
  logic         r_ppu_first;

  logic [2:0]   w_state;
  logic [LW:0]  w_num_lat;
  logic [A_W:0] w_a_lim_now;
  logic [A_W:0] w_a_lim;
  logic [W_W:0] w_w_next;
  logic [A_W:0] w_a_next;
  logic [C_W:0] w_c_next;
  logic [K_W:0] w_k_next;
  logic [LW:0]  w_l_next;
  logic         w_w_wrap;
  logic         w_a_wrap;
  logic         w_ch_end;
  logic         w_c_last;
  logic         w_k_last;
  logic         w_l_last;
  logic         w_need_input;
  logic         w_filter_have;
  logic         w_input_have;
  logic         w_stream_ok;
  logic         w_accept;

  // comp_count is looked up externally from issue_c, so a new channel's limit is only
  // visible in its first cycle; an empty channel turns that cycle into the SKIP bubble.
  assign w_a_lim_now = cfg_sparse_ch[r_c[C_W-1:0]] ? {1'b0, comp_count} : {1'b0, cfg_a_count};
  assign w_a_lim     = r_ch_first ? w_a_lim_now : r_a_lim;
  assign w_state     = (r_state == S_COMPUTE && r_ch_first && w_a_lim_now == '0) ? S_SKIP : r_state;

  assign w_w_next = r_w + F_STEP;
  assign w_a_next = r_a + I_STEP;
  assign w_c_next = r_c + (C_W+1)'(1);
  assign w_k_next = r_k + (K_W+1)'(1);
  assign w_l_next = r_layer + (LW+1)'(1);

  assign w_w_wrap = (w_w_next >= {1'b0, cfg_w_count});
  assign w_a_wrap = (w_a_next >= w_a_lim);
  assign w_ch_end = w_w_wrap & w_a_wrap;
  assign w_c_last = (w_c_next >= {1'b0, cfg_c_count});
  assign w_k_last = (w_k_next >= {1'b0, cfg_k_count});
  assign w_l_last = (w_l_next >= r_num_layers);

  assign w_need_input  = (r_k == '0);
  assign w_filter_have = r_filter_flag | filter_done;
  assign w_input_have  = r_input_flag | input_done;
  assign w_stream_ok   = w_filter_have & (w_input_have | ~w_need_input);

  // Handshake: a beat transfers on a cycle where issue_valid & issue_ready; while valid is
  // high and ready low every issue_* output holds, and valid never drops before the transfer.
  assign w_accept = (w_state == S_COMPUTE) & issue_ready;

  always_comb begin
    w_num_lat = cfg_num_layers;
    if (cfg_num_layers == '0)
      w_num_lat = (LW+1)'(1);
    else if (cfg_num_layers > (LW+1)'(MAX_LAYERS))
      w_num_lat = (LW+1)'(MAX_LAYERS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_layer       <= '0;
      r_num_layers  <= '0;
      r_k           <= '0;
      r_c           <= '0;
      r_a           <= '0;
      r_a_lim       <= '0;
      r_w           <= '0;
      r_filter_flag <= 1'b0;
      r_input_flag  <= 1'b0;
      r_ch_first    <= 1'b0;
      r_ppu_first   <= 1'b0;
    end else begin
      case (w_state)
        S_IDLE: begin
          if (start) begin
            r_num_layers  <= w_num_lat;
            r_layer       <= '0;
            r_k           <= '0;
            r_c           <= '0;
            r_a           <= '0;
            r_w           <= '0;
            r_filter_flag <= 1'b0;
            r_input_flag  <= 1'b0;
            r_state       <= S_STREAM;
          end
        end
        S_STREAM: begin
          r_filter_flag <= w_filter_have;
          r_input_flag  <= w_input_have;
          if (w_stream_ok) begin
            r_filter_flag <= 1'b0;
            r_input_flag  <= 1'b0;
            r_ch_first    <= 1'b1;
            r_state       <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (r_ch_first) begin
            r_a_lim    <= w_a_lim_now;
            r_ch_first <= 1'b0;
          end
          if (w_accept) begin
            if (!w_w_wrap) begin
              r_w <= w_w_next;
            end else begin
              r_w <= '0;
              if (!w_a_wrap) begin
                r_a <= w_a_next;
              end else begin
                r_a <= '0;
                if (w_c_last) begin
                  r_ppu_first <= 1'b1;
                  r_state     <= S_PPU;
                end else begin
                  r_c        <= w_c_next;
                  r_ch_first <= 1'b1;
                end
              end
            end
          end
        end
        S_SKIP: begin
          if (w_c_last) begin
            r_ch_first  <= 1'b0;
            r_ppu_first <= 1'b1;
            r_state     <= S_PPU;
          end else begin
            r_c        <= w_c_next;
            r_ch_first <= 1'b1;
          end
        end
        S_PPU: begin
          r_ppu_first <= 1'b0;
          if (ppu_done) begin
            r_c <= '0;
            r_a <= '0;
            r_w <= '0;
            if (!w_k_last) begin
              r_k     <= w_k_next;
              r_state <= S_STREAM;
            end else if (!w_l_last) begin
              r_layer <= w_l_next;
              r_k     <= '0;
              r_state <= S_STREAM;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_layer <= '0;
          r_k     <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_layer        = r_layer[LW-1:0];
  assign req_filter_valid = (r_state == S_STREAM);
  assign req_input_valid  = (r_state == S_STREAM) & w_need_input;
  assign req_k            = (r_state == S_STREAM) ? r_k[K_W-1:0] : '0;
  assign issue_valid      = (w_state == S_COMPUTE);
  assign issue_k          = (r_state == S_COMPUTE) ? r_k[K_W-1:0] : '0;
  assign issue_c          = (r_state == S_COMPUTE) ? r_c[C_W-1:0] : '0;
  assign issue_a          = (r_state == S_COMPUTE) ? r_a[A_W-1:0] : '0;
  assign issue_w          = (r_state == S_COMPUTE) ? r_w[W_W-1:0] : '0;
  assign issue_last       = issue_valid & w_ch_end & w_c_last;
  assign ppu_start        = (r_state == S_PPU) & r_ppu_first;
  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);
  assign dbg_state        = w_state;

endmodule

// File: tb/tb_pe_loop_sequencer.sv
// Directed bench for pe_loop_sequencer: per-cycle responder for streams/PPU/ready,
// expected-beat queue scoreboard, and one summary line.
module tb_pe_loop_sequencer;
  localparam int K_W = 6;
  localparam int C_W = 6;
  localparam int A_W = 10;
  localparam int W_W = 10;
  localparam int LW  = 2;
  localparam int BW  = 1 + K_W + C_W + A_W + W_W;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STREAM  = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_SKIP    = 3'd3;
  localparam logic [2:0] ST_PPU     = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start;
  logic [LW:0]       cfg_num_layers;
  logic [LW-1:0]     cfg_layer;
  logic [K_W-1:0]    cfg_k_count;
  logic [C_W-1:0]    cfg_c_count;
  logic [W_W-1:0]    cfg_w_count;
  logic [A_W-1:0]    cfg_a_count;
  logic [63:0]       cfg_sparse_ch;
  logic [A_W-1:0]    comp_count;
  logic              req_filter_valid, req_input_valid;
  logic [K_W-1:0]    req_k;
  logic              filter_done, input_done;
  logic              issue_valid, issue_ready;
  logic [K_W-1:0]    issue_k;
  logic [C_W-1:0]    issue_c;
  logic [A_W-1:0]    issue_a;
  logic [W_W-1:0]    issue_w;
  logic              issue_last, ppu_start, ppu_done, busy, done;
  logic [2:0]        dbg_state;

  logic [K_W-1:0] lay_k [4];
  logic [C_W-1:0] lay_c [4];
  logic [W_W-1:0] lay_w [4];
  logic [A_W-1:0] lay_a [4];
  logic [A_W-1:0] comp_tbl [64];

  assign cfg_k_count = lay_k[cfg_layer];
  assign cfg_c_count = lay_c[cfg_layer];
  assign cfg_w_count = lay_w[cfg_layer];
  assign cfg_a_count = lay_a[cfg_layer];
  assign comp_count  = comp_tbl[issue_c];

  pe_loop_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_layers(cfg_num_layers),
    .cfg_layer(cfg_layer), .cfg_k_count(cfg_k_count), .cfg_c_count(cfg_c_count),
    .cfg_w_count(cfg_w_count), .cfg_a_count(cfg_a_count), .cfg_sparse_ch(cfg_sparse_ch),
    .comp_count(comp_count), .req_filter_valid(req_filter_valid),
    .req_input_valid(req_input_valid), .req_k(req_k), .filter_done(filter_done),
    .input_done(input_done), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_k(issue_k), .issue_c(issue_c), .issue_a(issue_a), .issue_w(issue_w),
    .issue_last(issue_last), .ppu_start(ppu_start), .ppu_done(ppu_done),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] exp_q[$];
  int filt_delay, inp_delay, ppu_delay;
  int rdy_mode;
  logic man_ppu, man_filt;
  int cyc, acc_cnt, stall_cnt, ppu_cnt, done_cnt, skip_cnt, t_fd, t_comp, inreq_k0, inreq_k1;
  logic [7:0] layer_seq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] beat(input logic last, input int k, input int c,
                                          input int a, input int w);
    beat = {last, K_W'(k), C_W'(c), A_W'(a), W_W'(w)};
  endfunction

  // per-cycle responder and monitor, all on the falling edge
  initial begin : cycle_proc
    int s_cnt;
    int p_cnt;
    logic [2:0] prev_st;
    logic [BW-1:0] got_b;
    logic [BW-1:0] exp_b;
    s_cnt = 0;
    p_cnt = 0;
    prev_st = ST_IDLE;
    forever begin
      @(negedge clk);
      cyc++;
      if (rdy_mode == 1) issue_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else               issue_ready = 1'b1;
      if (req_filter_valid && !rst) begin
        filter_done = (s_cnt == filt_delay);
        input_done  = (s_cnt == inp_delay);
        s_cnt++;
      end else begin
        filter_done = 1'b0;
        input_done  = 1'b0;
        s_cnt = 0;
      end
      filter_done = filter_done | man_filt;
      if (dbg_state == ST_PPU && !rst) begin
        ppu_done = (p_cnt == ppu_delay);
        p_cnt++;
      end else begin
        ppu_done = 1'b0;
        p_cnt = 0;
      end
      ppu_done = ppu_done | man_ppu;
      if (!rst) begin
        got_b = {issue_last, issue_k, issue_c, issue_a, issue_w};
        if (issue_valid) begin
          check("beat_avail", (exp_q.size() > 0), 1'b1);
          if (exp_q.size() > 0) begin
            exp_b = exp_q[0];
            if (issue_ready) begin
              acc_cnt++;
              exp_b = exp_q.pop_front();
              check("beat", got_b, exp_b);
            end else begin
              stall_cnt++;
              check("stall_hold", got_b, exp_b);
            end
          end
        end
        if (ppu_start) begin
          ppu_cnt++;
          layer_seq = {layer_seq[5:0], cfg_layer};
        end
        if (done) done_cnt++;
        if (dbg_state == ST_SKIP) skip_cnt++;
        if (filter_done && req_k == '0 && t_fd < 0) t_fd = cyc;
        if (dbg_state == ST_COMPUTE && prev_st == ST_STREAM && t_comp < 0) t_comp = cyc;
        if (req_input_valid && req_k == K_W'(0)) inreq_k0++;
        if (req_input_valid && req_k == K_W'(1)) inreq_k1++;
        prev_st = dbg_state;
      end
    end
  end

  // driver tasks
  task automatic set_layer(input int l, input int k, input int c, input int w, input int a);
    lay_k[l] = K_W'(k);
    lay_c[l] = C_W'(c);
    lay_w[l] = W_W'(w);
    lay_a[l] = A_W'(a);
  endtask

  task automatic clear_stats();
    acc_cnt = 0; stall_cnt = 0; ppu_cnt = 0; done_cnt = 0; skip_cnt = 0;
    t_fd = -1; t_comp = -1; inreq_k0 = 0; inreq_k1 = 0; layer_seq = '0;
    exp_q.delete();
  endtask

  task automatic run(input string tag, input int nl, input int budget, input bit mid_start);
    bit seen;
    seen = 1'b0;
    cfg_num_layers = (LW+1)'(nl);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      start = (mid_start && (i == 10 || i == 25));
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, seen, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_idle_after"}, dbg_state, ST_IDLE);
    check({tag, "_beats_left"}, exp_q.size(), 0);
  endtask

  task automatic push_t1();
    exp_q.push_back(beat(0, 0, 0, 0, 0));
    exp_q.push_back(beat(0, 0, 0, 0, 4));
    exp_q.push_back(beat(0, 0, 0, 4, 0));
    exp_q.push_back(beat(1, 0, 0, 4, 4));
  endtask

  initial begin : main
    bit hit;
    rst = 1'b1; start = 1'b0; cfg_num_layers = '0; cfg_sparse_ch = '0;
    issue_ready = 1'b1; filter_done = 1'b0; input_done = 1'b0; ppu_done = 1'b0;
    man_ppu = 1'b0; man_filt = 1'b0; rdy_mode = 0;
    filt_delay = 0; inp_delay = 0; ppu_delay = 2; cyc = 0;
    for (int i = 0; i < 4; i++) set_layer(i, 1, 1, 4, 4);
    for (int i = 0; i < 64; i++) comp_tbl[i] = '0;
    clear_stats();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_issue", {issue_valid, issue_last, issue_k, issue_c, issue_a, issue_w}, '0);
    check("rst_req", {req_filter_valid, req_input_valid, req_k}, '0);
    check("rst_ppu_layer", {ppu_start, cfg_layer}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: single dense layer, 4 beats
    clear_stats();
    set_layer(0, 1, 1, 8, 8);
    push_t1();
    run("t1", 1, 200, 1'b0);
    check("t1_acc", acc_cnt, 4);
    check("t1_ppu", ppu_cnt, 1);
    check("t1_done", done_cnt, 1);

    // T2: input_done 3 cycles ahead of filter_done, k=2
    clear_stats();
    filt_delay = 3; inp_delay = 0;
    set_layer(0, 2, 1, 4, 4);
    exp_q.push_back(beat(1, 0, 0, 0, 0));
    exp_q.push_back(beat(1, 1, 0, 0, 0));
    run("t2", 1, 200, 1'b0);
    check("t2_fd_seen", (t_fd >= 0), 1'b1);
    check("t2_compute_lat", t_comp - t_fd, 1);
    check("t2_inreq_k0", inreq_k0, 4);
    check("t2_inreq_k1", inreq_k1, 0);
    check("t2_ppu", ppu_cnt, 2);
    filt_delay = 0;

    // T3: sparse ch0 (5 acts) then empty sparse ch1
    clear_stats();
    cfg_sparse_ch = 64'h3;
    comp_tbl[0] = 10'd5; comp_tbl[1] = 10'd0;
    set_layer(0, 1, 2, 4, 8);
    exp_q.push_back(beat(0, 0, 0, 0, 0));
    exp_q.push_back(beat(0, 0, 0, 4, 0));
    run("t3", 1, 200, 1'b0);
    check("t3_acc", acc_cnt, 2);
    check("t3_skip", skip_cnt, 1);
    check("t3_ppu", ppu_cnt, 1);

    // T3b: dense ch0 then sparse ch1 with 3 acts
    clear_stats();
    cfg_sparse_ch = 64'h2;
    comp_tbl[1] = 10'd3;
    set_layer(0, 1, 2, 8, 4);
    exp_q.push_back(beat(0, 0, 0, 0, 0));
    exp_q.push_back(beat(0, 0, 0, 0, 4));
    exp_q.push_back(beat(0, 0, 1, 0, 0));
    exp_q.push_back(beat(1, 0, 1, 0, 4));
    run("t3b", 1, 200, 1'b0);
    check("t3b_acc", acc_cnt, 4);
    check("t3b_skip", skip_cnt, 0);
    cfg_sparse_ch = '0;

    // T4: ready pattern 1,0,0,1
    clear_stats();
    rdy_mode = 1;
    set_layer(0, 1, 1, 8, 8);
    push_t1();
    run("t4", 1, 300, 1'b0);
    check("t4_acc", acc_cnt, 4);
    check("t4_stalled", (stall_cnt > 0), 1'b1);
    rdy_mode = 0;

    // T5: two layers x two k-groups, stray starts while busy
    clear_stats();
    set_layer(0, 2, 1, 4, 4);
    set_layer(1, 2, 1, 4, 8);
    exp_q.push_back(beat(1, 0, 0, 0, 0));
    exp_q.push_back(beat(1, 1, 0, 0, 0));
    exp_q.push_back(beat(0, 0, 0, 0, 0));
    exp_q.push_back(beat(1, 0, 0, 4, 0));
    exp_q.push_back(beat(0, 1, 0, 0, 0));
    exp_q.push_back(beat(1, 1, 0, 4, 0));
    run("t5", 2, 400, 1'b1);
    check("t5_ppu", ppu_cnt, 4);
    check("t5_layers", layer_seq, 8'h05);
    check("t5_done", done_cnt, 1);
    check("t5_acc", acc_cnt, 6);

    // T6: reset in the middle of COMPUTE
    clear_stats();
    set_layer(0, 1, 1, 4, 16);
    exp_q.push_back(beat(0, 0, 0, 0, 0));
    exp_q.push_back(beat(0, 0, 0, 4, 0));
    exp_q.push_back(beat(0, 0, 0, 8, 0));
    exp_q.push_back(beat(1, 0, 0, 12, 0));
    cfg_num_layers = 3'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc_cnt >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    check("t6_reached_compute", hit, 1'b1);
    check("t6_pre_state", dbg_state, ST_COMPUTE);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_state", dbg_state, ST_IDLE);
    check("t6_issue", {issue_valid, issue_last, issue_k, issue_c, issue_a, issue_w}, '0);
    check("t6_misc", {busy, done, ppu_start, req_filter_valid, req_input_valid, req_k, cfg_layer}, '0);
    rst = 1'b0;
    exp_q.delete();
    man_ppu = 1'b1; man_filt = 1'b1;
    @(posedge clk); #1;
    man_ppu = 1'b0; man_filt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_ignored_state", dbg_state, ST_IDLE);
    check("t6_no_done", done_cnt, 0);
    check("t6_no_ppu", ppu_cnt, 0);

    // restart after the abort runs from layer 0
    clear_stats();
    set_layer(0, 1, 1, 8, 8);
    push_t1();
    run("t6r", 1, 200, 1'b0);
    check("t6r_acc", acc_cnt, 4);
    check("t6r_ppu", ppu_cnt, 1);
    check("t6r_layer", layer_seq, 8'h00);
    check("t6r_done", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
